// File: rtl/mul_kn_pipe.sv
// mul_kn_pipe: four-stage pipelined fixed-point scaler by a CORDIC gain constant.
// mode=0 multiplies by Kc (circular gain), mode=1 by 1/Kh (inverse hyperbolic gain).
// Optional build macro MUL_KN_SAT_EN: saturate overflowed results instead of wrapping.
// Every stage, including its valid bit, moves on advance = ce & (~out_valid | out_ready).
module mul_kn_pipe #(
    parameter int W  = 12,
    parameter int CF = 14
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] value_in,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] value_out,
    output logic                ovf_flag,
    input  logic                ovf_clr
);

    // Coefficient is below 2^(CF+1), so CF+2 bits hold it as a positive signed value.
    localparam int CW   = CF + 2;
    localparam int PW   = W + CF + 2;
    localparam int RW   = PW - CF;
    localparam int LO   = CW / 2;
    localparam int HI   = CW - LO;
    localparam int PPLW = W + LO + 1;
    localparam int PPHW = W + HI;

    localparam real KC_R  = 0.6072529350;
    localparam real KH_R  = 1.2074970678;
    localparam real SCALE = 2.0 ** CF;
    localparam int  KC_I  = $rtoi(KC_R * SCALE + 0.5);
    localparam int  KH_I  = $rtoi(KH_R * SCALE + 0.5);

    localparam logic signed [CW-1:0] KC_Q = KC_I[CW-1:0];
    localparam logic signed [CW-1:0] KH_Q = KH_I[CW-1:0];

    localparam logic signed [PW-1:0] HALF  = {{(PW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};
    localparam logic signed [W-1:0]  MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_V = {1'b1, {(W-1){1'b0}}};

    logic advance;

    logic                 s1_valid;
    logic signed [W-1:0]  s1_op;
    logic signed [CW-1:0] s1_coef;

    logic                   s2_valid;
    logic signed [PPLW-1:0] s2_pp_lo;
    logic signed [PPHW-1:0] s2_pp_hi;

    logic                 s3_valid;
    logic signed [PW-1:0] s3_prod;

    logic signed [PPLW-1:0] pp_lo_c;
    logic signed [PPHW-1:0] pp_hi_c;
    logic signed [RW-1:0]   rnd_c;
    logic [2:0]             top_c;
    logic                   ovf_c;
    logic signed [W-1:0]    res_c;

    // Handshake: the whole pipe advances only when the output slot is free or draining.
    always_comb begin
        advance  = ce & (~out_valid | out_ready);
        in_ready = reset_n & advance;
    end

    // Partial products: signed operand times unsigned low half and signed high half of the coefficient.
    always_comb begin
        pp_lo_c = PPLW'(s1_op) * PPLW'($signed({1'b0, s1_coef[LO-1:0]}));
        pp_hi_c = PPHW'(s1_op) * PPHW'($signed(s1_coef[CW-1:LO]));
    end

    // Round half up, range check on the three top bits, then wrap or saturate.
    always_comb begin
        rnd_c = RW'((s3_prod + HALF) >>> CF);
        top_c = rnd_c[RW-1:W-1];
        ovf_c = ~((&top_c) | (~|top_c));
`ifdef MUL_KN_SAT_EN
        if (ovf_c) begin
            res_c = rnd_c[RW-1] ? MIN_V : MAX_V;
        end else begin
            res_c = rnd_c[W-1:0];
        end
`else
        res_c = rnd_c[W-1:0];
`endif
    end

    // S1: capture operand and mode-selected coefficient at acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_coef  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_op    <= value_in;
            s1_coef  <= mode ? KH_Q : KC_Q;
        end
    end

    // S2: register the two partial products.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_pp_lo <= '0;
            s2_pp_hi <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_pp_lo <= pp_lo_c;
            s2_pp_hi <= pp_hi_c;
        end
    end

    // S3: sum the shifted partial products into the exact full product.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid <= 1'b0;
            s3_prod  <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_prod  <= (PW'(s2_pp_hi) <<< LO) + PW'(s2_pp_lo);
        end
    end

    // S4: register the rounded, range-handled result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            value_out <= '0;
        end else if (advance) begin
            out_valid <= s3_valid;
            value_out <= res_c;
        end
    end

    // Sticky overflow: a new overflow entering S4 wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_flag <= 1'b0;
        end else if (ce) begin
            if (advance && s3_valid && ovf_c) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_kn_pipe.sv
// Testbench for mul_kn_pipe (W=12, CF=14), scoreboard plus directed latency/value checks.
module tb_mul_kn_pipe;

    localparam int W = 12;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic ce = 1'b0;
    logic in_valid = 1'b0;
    logic mode = 1'b0;
    logic out_ready = 1'b1;
    logic ovf_clr = 1'b0;
    logic signed [W-1:0] value_in = '0;
    logic in_ready, out_valid, ovf_flag;
    logic signed [W-1:0] value_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W:0] sb[$];

    logic prev_stall = 1'b0;
    logic signed [W-1:0] prev_val = '0;

    always #5 clock = ~clock;

    mul_kn_pipe #(.W(W), .CF(14)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_ready(in_ready), .value_in(value_in), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .value_out(value_out),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product, round half up, wrap or saturate to W bits; bit W = overflow.
    function automatic logic [W:0] model(input int v, input bit m);
        longint p, r;
        logic [63:0] rb;
        logic o;
        logic [W-1:0] val;
        p  = longint'(v) * (m ? 64'sd19784 : 64'sd9949);
        r  = (p + 64'sd8192) >>> 14;
        o  = (r > 2047) || (r < -2048);
        rb = r;
        val = rb[W-1:0];
`ifdef MUL_KN_SAT_EN
        if (r > 2047)  val = 12'h7ff;
        if (r < -2048) val = 12'h800;
`endif
        return {o, val};
    endfunction

    task automatic send(input int v, input bit m);
        int budget = 0;
        logic rdy;
        in_valid = 1'b1;
        value_in = W'(v);
        mode = m;
        do begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            budget++;
        end while (!rdy && budget < 200);
        chk("accept", rdy, 1);
        if (rdy) sb.push_back(model(v, m));
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_one(input string tag, input int v, input bit m, input int expv, input bit expo);
        int n;
        out_ready = 1'b1;
        send(v, m);
        in_valid = 1'b0;
        @(negedge clock);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_value"}, value_out, expv);
        chk({tag, "_ovf"}, ovf_flag, expo);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard pop on each output handshake, plus hold check while stalled.
    always @(negedge clock) begin
        logic [W:0] e;
        if (reset_n && ce && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_output", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_value", value_out, $signed(e[W-1:0]));
                if (e[W]) chk("sb_ovf", ovf_flag, 1);
            end
        end
        if (prev_stall && reset_n) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", value_out, prev_val);
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_val = value_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int vals[8];
        int budget;
        longint t0;
        vals = '{100, -300, 2047, -2048, 5, -7, 1500, -1500};
        pat = 4'b1001;

        // Reset state
        #2 reset_n = 1'b0;
        ce = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_value_out", value_out, 0);
        chk("rst_ovf", ovf_flag, 0);
        chk("rst_in_ready", in_ready, 0);
        cycles(3);
        #2 reset_n = 1'b1;
        cycles(1);

        check_one("kc_pos", 1024, 1'b0, 622, 1'b0);
        check_one("kh_pos", 1024, 1'b1, 1237, 1'b0);
        check_one("kc_neg", -1024, 1'b0, -622, 1'b0);
`ifdef MUL_KN_SAT_EN
        check_one("kh_max", 2047, 1'b1, 2047, 1'b1);
`else
        check_one("kh_max", 2047, 1'b1, -1624, 1'b1);
`endif
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        chk("ovf_clear", ovf_flag, 0);
`ifdef MUL_KN_SAT_EN
        check_one("kh_min", -2048, 1'b1, -2048, 1'b1);
`else
        check_one("kh_min", -2048, 1'b1, 1623, 1'b1);
`endif

        // Stall with output held, then freeze with ce=0 (flag stays set despite ovf_clr)
        out_ready = 1'b0;
        send(500, 1'b0);
        in_valid = 1'b0;
        cycles(5);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_value", value_out, 304);
        chk("stall_in_ready", in_ready, 0);
        ce = 1'b0;
        ovf_clr = 1'b1;
        in_valid = 1'b1;
        value_in = 12'sd7;
        cycles(3);
        chk("ce0_in_ready", in_ready, 0);
        chk("ce0_ovf_hold", ovf_flag, 1);
        chk("ce0_value_hold", value_out, 304);
        in_valid = 1'b0;
        ce = 1'b1;
        cycles(1);
        chk("ce1_ovf_clr", ovf_flag, 0);
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        cycles(2);

        // Set beats simultaneous clear
        ovf_clr = 1'b1;
`ifdef MUL_KN_SAT_EN
        check_one("set_prio", 2047, 1'b1, 2047, 1'b1);
`else
        check_one("set_prio", 2047, 1'b1, -1624, 1'b1);
`endif
        chk("clr_after_set", ovf_flag, 0);
        ovf_clr = 1'b0;

        // Back-to-back burst with out_ready pattern 1,0,0,1
        fork
            begin
                for (int i = 0; i < 8; i++) send(vals[i], i[0]);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = pat[c % 4];
                    @(posedge clock);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            cycles(1);
            budget++;
        end
        chk("burst_drain", sb.size(), 0);

        // Full throughput with out_ready=1
        t0 = $time;
        for (int i = 0; i < 6; i++) send(i * 300 - 800, i[1]);
        in_valid = 1'b0;
        chk("throughput_cycles", int'(($time - t0) / 10), 6);
        cycles(6);

        // Reset with three samples in flight
        send(100, 1'b0);
        send(200, 1'b1);
        send(300, 1'b0);
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_ovf", ovf_flag, 0);
        cycles(2);
        #2 reset_n = 1'b1;
        cycles(1);
        check_one("post_rst", -700, 1'b1, -845, 1'b0);

        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            cycles(1);
            budget++;
        end
        chk("final_drain", sb.size(), 0);
        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_kn_pipe.md
MUL_KN_PIPE -- requirements
Module: mul_kn_pipe

Interface
REQ-001 SHALL have parameter W, default 12: signed sample width in fixed-point (W:FXP) format, legal range 8..32.
REQ-002 SHALL have parameter CF, default 14: coefficient fraction bits, legal range 10..20.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ce, input, 1: clock enable; when 0, all state holds.
REQ-006 SHALL have port in_valid, input, 1: value_in and mode are valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port value_in, input, W, signed: sample to be scaled.
REQ-009 SHALL have port mode, input, 1: 0 selects circular gain Kc = 0.6072529350; 1 selects inverse hyperbolic gain 1/Kh = 1.2074970678.
REQ-010 SHALL have port out_valid, output, 1: value_out is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts value_out.
REQ-012 SHALL have port value_out, output, W, signed: scaled result.
REQ-013 SHALL have port ovf_flag, output, 1: sticky overflow indicator.
REQ-014 SHALL have port ovf_clr, input, 1: synchronous clear of ovf_flag.

Function
REQ-015 SHALL compute the coefficients at elaboration as round(K*2^CF): with CF=14, Kc is 9949 and 1/Kh is 19784.
REQ-016 SHALL define advance = ce AND (NOT out_valid OR out_ready), and drive in_ready = advance.
REQ-017 SHALL accept a sample only when in_valid AND in_ready are both 1.
REQ-018 SHALL move all pipeline stages, including their valid bits, together on advance and hold them all otherwise.
REQ-019 SHALL use 4 pipeline stages: S1 registers the operand and coefficient, S2 forms the partial products, S3 sums them, S4 rounds, checks range and registers the output.
REQ-020 SHALL give a fixed latency of 4 advance cycles from acceptance to out_valid=1.
REQ-021 SHALL sustain 1 sample per cycle when out_ready=1 and ce=1.
REQ-022 SHALL capture mode together with value_in at acceptance, so mode changes never affect samples already in flight.
REQ-023 SHALL compute an exact signed full product of width W+CF+2.
REQ-024 SHALL round half up: add 2^(CF-1), then arithmetic-shift right by CF.
REQ-025 SHALL treat a rounded result outside [-2^(W-1), 2^(W-1)-1] as an overflow; its handling is per REQ-034/REQ-035.
REQ-026 SHALL hold value_out and out_valid stable while out_valid=1 and out_ready=0, regardless of in_valid.
REQ-027 SHALL, when ce=0, keep in_ready=0 and freeze all outputs and state, including ovf_flag.
REQ-028 SHALL set ovf_flag at the cycle an overflowed result is registered in S4.
REQ-029 SHALL give set priority over ovf_clr when both occur in the same cycle.

Reset
REQ-030 SHALL, on reset_n=0, immediately clear all stage valid bits, out_valid, value_out and ovf_flag to 0.
REQ-031 SHALL hold in_ready=0 while reset_n=0.
REQ-032 SHALL discard in-flight samples on reset assertion mid-operation; they never appear on value_out.
REQ-033 SHALL release reset cleanly: the first sample accepted after release emerges after exactly 4 advance cycles.

Configuration
REQ-034 SHALL, with macro MUL_KN_SAT_EN defined, saturate an overflowed result to 2^(W-1)-1 or -2^(W-1) according to sign.
REQ-035 SHALL, without MUL_KN_SAT_EN, wrap an overflowed result (keep the low W bits); ovf_flag reports overflow in both builds.

Verification
REQ-036 SHALL cover: W=12, mode=0, value_in=1024 -> value_out=622 after 4 cycles, ovf_flag=0.
REQ-037 SHALL cover: mode=1, value_in=1024 -> value_out=1237; mode=0, value_in=-1024 -> value_out=-622.
REQ-038 SHALL cover: mode=1, value_in=2047 -> value_out=2047 with MUL_KN_SAT_EN or -1624 without, ovf_flag=1 in both; then ovf_clr=1 -> ovf_flag=0.
REQ-039 SHALL cover: mode=1, value_in=-2048 -> value_out=-2048 with MUL_KN_SAT_EN, ovf_flag=1.
REQ-040 SHALL cover: 8 back-to-back samples with out_ready toggling 1,0,0,1 -> no loss, duplication or reordering, and value_out stable while stalled.
REQ-041 SHALL cover: reset_n pulsed low with 3 samples in flight -> out_valid=0 immediately, none of the 3 is output, next accepted sample appears 4 cycles later.
